// File: rtl/refclk_pkg.sv
// Shared types and pattern constants for the forwarded reference clock.
package refclk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // ODDR data patterns: bit 0 = rising half, bit 1 = falling half
  localparam logic [1:0] PAT_PARK = 2'b00;
  localparam logic [1:0] PAT_FULL = 2'b01;

  // Pick the P-pad pattern for one CLK cycle
  function automatic logic [1:0] pat_sel(input logic toggling, input logic full, input logic phase);
    if (!toggling) return PAT_PARK;
    if (full)      return PAT_FULL;
    return {phase, phase};
  endfunction

endpackage

// File: rtl/refclk_div_cnt.sv
// Half-period counter: counts 0..div-1 and toggles phase on each wrap.
// A load restarts the count with phase high so every start begins with a full high half.
module refclk_div_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_run,
  output logic             o_phase,
  output logic             o_wrap
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_phase;
  logic [DIV_W-1:0] w_last;

  assign w_last  = i_div - DIV_W'(1);
  // div==0 is full-rate; the counter is idle then and never wraps
  assign o_wrap  = (i_div != '0) && (r_cnt == w_last);
  assign o_phase = r_phase;

  // Counter and phase register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (i_run && (i_div != '0)) begin
      if (o_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/refclk_fwd.sv
// Forwarded differential reference clock: ODDR data for P/N pads with a
// glitch-free start/stop handshake and RUNNING/STOPPED status.
module refclk_fwd
  import refclk_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int START_CYCLES = 16,
  parameter int STOP_HOLD    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  output logic [1:0]       REFCLKP_D,
  output logic [1:0]       REFCLKN_D,
  output logic             RUNNING,
  output logic             STOPPED
);

  localparam int SC_W = $clog2(START_CYCLES + 1);
  localparam int HC_W = $clog2(STOP_HOLD + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(STOP_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div_q, w_div_nxt;
  logic [SC_W-1:0]  r_scnt,  w_scnt_nxt;
  logic [HC_W-1:0]  r_hcnt,  w_hcnt_nxt;
  logic [1:0]       r_p, r_n;
  logic             r_running, r_stopped;

  logic             w_load, w_run, w_phase, w_wrap, w_phase_nxt;
  logic             w_drain, w_tog;
  logic [1:0]       w_p_nxt;

  refclk_div_cnt #(.DIV_W(DIV_W)) u_div_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_div   (r_div_q),
    .i_run   (w_run),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  // Phase as it will be after this edge, so the output register lines up with it
  assign w_phase_nxt = w_load ? 1'b1 : ((w_run && w_wrap) ? ~w_phase : w_phase);

  // A stop only needs draining while a high half is in progress and not ending now
  assign w_drain = (r_div_q != '0) && w_phase && !w_wrap;

  // Next-state, counter and divider-latch logic
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_q;
    w_scnt_nxt  = r_scnt;
    w_hcnt_nxt  = r_hcnt;
    w_load      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (EN) begin
          w_load      = 1'b1;
          w_div_nxt   = DIV;
          w_scnt_nxt  = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START, ST_RUN: begin
        w_run = 1'b1;
        if (!EN) begin
          w_state_nxt = w_drain ? ST_DRAIN : ST_HOLD;
          w_hcnt_nxt  = '0;
        end else if (r_state == ST_START) begin
          w_scnt_nxt = r_scnt + SC_W'(1);
          if (r_scnt == SC_LAST) w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_run = 1'b1;
        // wrap here means the high half just finished
        if (w_wrap) begin
          w_state_nxt = ST_HOLD;
          w_hcnt_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (r_hcnt == HC_LAST) w_state_nxt = ST_IDLE;
        else                   w_hcnt_nxt  = r_hcnt + HC_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_tog   = (w_state_nxt == ST_START) || (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
  assign w_p_nxt = pat_sel(w_tog, w_div_nxt == '0, w_phase_nxt);

  // State, counters and registered outputs; reset parks the pads at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_div_q   <= '0;
      r_scnt    <= '0;
      r_hcnt    <= '0;
      r_p       <= PAT_PARK;
      r_n       <= ~PAT_PARK;
      r_running <= 1'b0;
      r_stopped <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div_q   <= w_div_nxt;
      r_scnt    <= w_scnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_p       <= w_p_nxt;
      r_n       <= ~w_p_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_stopped <= (w_state_nxt == ST_IDLE);
    end
  end

  assign REFCLKP_D = r_p;
  assign REFCLKN_D = r_n;
  assign RUNNING   = r_running;
  assign STOPPED   = r_stopped;

endmodule

// File: tb/tb_refclk_fwd.sv
// Bench for refclk_fwd: behavioural model feeds a per-cycle scoreboard,
// plus directed checks on latencies, patterns and stop timing.
module tb_refclk_fwd;

  localparam int DW = 8;
  localparam int SC = 16;
  localparam int SH = 4;

  typedef struct packed {
    logic [1:0] p;
    logic [1:0] n;
    logic       run;
    logic       stp;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic [DW-1:0] DIV;
  logic [1:0]    REFCLKP_D, REFCLKN_D;
  logic          RUNNING, STOPPED;

  refclk_fwd #(.DIV_W(DW), .START_CYCLES(SC), .STOP_HOLD(SH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV),
    .REFCLKP_D(REFCLKP_D), .REFCLKN_D(REFCLKN_D),
    .RUNNING(RUNNING), .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  int   chks = 0;
  int   errs = 0;
  exp_t sbq[$];

  // model state: 0 idle, 1 start, 2 run, 3 drain, 4 hold
  int m_st, m_div, m_cnt, m_scnt, m_hcnt;
  bit m_ph;

  logic [1:0] obs_p;
  logic       obs_run, obs_stp, seen_run;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_div = 0; m_cnt = 0; m_scnt = 0; m_hcnt = 0; m_ph = 0;
  endtask

  task automatic adv();
    if (m_div != 0) begin
      if (m_cnt == m_div - 1) begin m_cnt = 0; m_ph = !m_ph; end
      else m_cnt++;
    end
  endtask

  task automatic model_edge();
    bit hi_end, park;
    if (RST) begin m_reset(); return; end
    hi_end = (m_div != 0) && m_ph && (m_cnt == m_div - 1);
    case (m_st)
      0: if (EN) begin m_div = int'(DIV); m_ph = 1; m_cnt = 0; m_scnt = 0; m_st = 1; end
      1, 2: begin
        park = (m_div == 0) || !m_ph || hi_end;
        adv();
        if (!EN) begin m_st = park ? 4 : 3; m_hcnt = 0; end
        else if (m_st == 1) begin
          if (m_scnt == SC - 1) m_st = 2;
          m_scnt++;
        end
      end
      3: begin adv(); if (hi_end) begin m_st = 4; m_hcnt = 0; end end
      default: begin m_hcnt++; if (m_hcnt == SH) m_st = 0; end
    endcase
  endtask

  // One clock: model pushes its expectation at the edge, DUT is compared at the negedge
  task automatic cyc();
    exp_t e;
    @(posedge CLK);
    model_edge();
    e.p   = (m_st >= 1 && m_st <= 3) ? ((m_div == 0) ? 2'b01 : {m_ph, m_ph}) : 2'b00;
    e.n   = ~e.p;
    e.run = (m_st == 2);
    e.stp = (m_st == 0);
    sbq.push_back(e);
    @(negedge CLK);
    obs_p = REFCLKP_D; obs_run = RUNNING; obs_stp = STOPPED;
    seen_run = seen_run | RUNNING;
    if (sbq.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sbq.pop_front();
      chk("sb_p",   REFCLKP_D, e.p);
      chk("sb_n",   REFCLKN_D, e.n);
      chk("sb_run", RUNNING,   e.run);
      chk("sb_stp", STOPPED,   e.stp);
    end
  endtask

  task automatic wait_stop();
    int n;
    n = 0;
    while (!obs_stp && n < 600) begin cyc(); n++; end
    if (!obs_stp) chk("stop_timeout", 0, 1);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_p"},   REFCLKP_D, 2'b00);
    chk({tag, "_n"},   REFCLKN_D, 2'b11);
    chk({tag, "_run"}, RUNNING,   1'b0);
    chk({tag, "_stp"}, STOPPED,   1'b1);
  endtask

  // Reset asserted between edges must park the outputs without a clock
  task automatic async_rst();
    #2 RST = 1'b1;
    #1 rst_check("arst");
    m_reset();
    cyc(); cyc();
    RST = 1'b0;
  endtask

  initial begin
    int n, nhi;
    RST = 1'b1; EN = 1'b0; DIV = '0; seen_run = 1'b0;
    obs_p = '0; obs_run = 1'b0; obs_stp = 1'b1;
    m_reset();
    #3 rst_check("rst");
    cyc(); cyc();
    RST = 1'b0;
    cyc();

    // full rate start
    EN = 1'b1; DIV = 8'd0;
    cyc();
    chk("t2_stp_fall", obs_stp, 1'b0);
    chk("t2_p_full",   obs_p,   2'b01);
    chk("t2_n_full",   REFCLKN_D, 2'b10);
    n = 1;
    while (!obs_run && n < 40) begin cyc(); n++; end
    chk("t2_run_lat", n, 17);
    EN = 1'b0;
    cyc();
    chk("t2_park", obs_p, 2'b00);
    wait_stop();

    // divide by 3, DIV change during RUN ignored
    EN = 1'b1; DIV = 8'd3;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) DIV = 8'd5;
      cyc();
      chk("t3_seq", obs_p, ((i % 6) < 3) ? 2'b11 : 2'b00);
    end
    EN = 1'b0;
    wait_stop();

    // maximum divider: first high half lasts 255 cycles
    EN = 1'b1; DIV = 8'd255;
    nhi = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (obs_p != 2'b11) break;
      nhi++;
    end
    chk("tmax_hi_len", nhi, 255);
    EN = 1'b0;
    wait_stop();

    // glitch-free stop: drop EN on the 2nd cycle of a high half
    EN = 1'b1; DIV = 8'd4;
    for (int k = 0; k < 18; k++) cyc();
    EN = 1'b0;
    cyc();
    chk("t4_run_fall", obs_run, 1'b0);
    nhi = (obs_p == 2'b11) ? 1 : 0;
    n = 0;
    while (obs_p == 2'b11 && n < 20) begin cyc(); n++; if (obs_p == 2'b11) nhi++; end
    chk("t4_drain_hi", nhi, 2);
    chk("t4_parked",   obs_p, 2'b00);
    n = 0;
    while (!obs_stp && n < 20) begin cyc(); n++; end
    chk("t4_hold_len", n, 4);

    // stop in low half parks on the next cycle
    EN = 1'b1; DIV = 8'd4;
    for (int k = 0; k < 22; k++) cyc();
    EN = 1'b0;
    cyc();
    chk("t5_park", obs_p, 2'b00);
    wait_stop();
    // early stop inside START: RUNNING never asserts
    seen_run = 1'b0;
    EN = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    EN = 1'b0;
    wait_stop();
    chk("t5_no_run", seen_run, 1'b0);

    // EN 1->0->1 inside DRAIN: stop completes, 1 IDLE cycle, restart with new DIV
    EN = 1'b1; DIV = 8'd4;
    for (int k = 0; k < 17; k++) cyc();
    EN = 1'b0;
    cyc();
    EN = 1'b1; DIV = 8'd2;
    wait_stop();
    cyc();
    chk("t6_idle_1cyc", obs_stp, 1'b0);
    chk("t6_p0", obs_p, 2'b11);
    cyc();
    chk("t6_p1", obs_p, 2'b11);
    cyc();
    chk("t6_p2", obs_p, 2'b00);

    // reset during RUN, then a clean start
    n = 0;
    while (!obs_run && n < 40) begin cyc(); n++; end
    chk("t6_in_run", obs_run, 1'b1);
    async_rst();
    n = 0;
    while (!obs_run && n < 40) begin cyc(); n++; end
    chk("t6_rerun_lat", n, 17);
    EN = 1'b0;
    wait_stop();
    cyc();

    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule

// File: doc/refclk_fwd.md
Name: refclk_fwd

Overview:
- Transmit-side counterpart of the SERDES external reference-clock input buffer: generates a forwarded differential reference clock for an off-chip SERDES or PLL.
- Produces per-cycle 2-bit DDR output-register data for the P and N pads; the pads themselves are driven by ODDRX1F instances outside this block.
- Supports a programmable divider, a glitch-free start/stop handshake, and RUNNING/STOPPED status for the PHY init sequencer.

Parameters:
- DIV_W, 8: width of the DIV input and of the half-period counter.
- START_CYCLES, 16: CLK cycles of toggling after start before RUNNING asserts; must be at least 1.
- STOP_HOLD, 4: CLK cycles the clock is held parked low after a stop before STOPPED asserts; must be at least 1.

Ports:
- CLK, input, 1: system clock; also the ODDR clock.
- RST, input, 1: asynchronous reset, active-high.
- EN, input, 1: level request. 1 = run, 0 = stop.
- DIV, input, DIV_W: half-period in CLK cycles. 0 = full-rate (output frequency equals CLK). Sampled only on leaving IDLE.
- REFCLKP_D, output, 2: ODDR data for the P pad. Bit 0 goes out on the rising edge, bit 1 on the falling edge.
- REFCLKN_D, output, 2: ODDR data for the N pad. Always the bitwise inverse of REFCLKP_D.
- RUNNING, output, 1: clock is stable at the latched divider.
- STOPPED, output, 1: clock is parked low and the block is idle.

Behaviour:
- Reset (async, RST=1): state=IDLE, REFCLKP_D=00, REFCLKN_D=11, RUNNING=0, STOPPED=1, cnt=0, phase=0, div_q=0.
- All outputs are registered.
- Pattern generation:
  - div_q==0: P=2'b01 (high on rising half, low on falling half) every cycle.
  - div_q=N>0: P={phase,phase}. cnt counts 0..N-1; at cnt==N-1, phase toggles and cnt returns to 0. Period is 2N CLK cycles, 50% duty.
  - Parked: P=00.
- FSM states:
  - IDLE: parked, STOPPED=1. When EN=1: latch div_q<=DIV, set phase=1, cnt=0, scnt=0, go to START. STOPPED drops on the same edge.
  - START: toggling; scnt increments each cycle. When scnt==START_CYCLES-1 and EN=1, go to RUN; RUNNING=1 from the first RUN cycle. If EN=0, go to DRAIN.
  - RUN: toggling, RUNNING=1. If EN=0, go to DRAIN; RUNNING drops on that edge.
  - DRAIN: keeps toggling until the high half-period completes, so a high pulse is never truncated. Low halves may be truncated.
    - div_q==0, or phase==0 on entry: park at once and go to HOLD.
    - Otherwise: when phase toggles to 0, park and go to HOLD.
  - HOLD: parked. hcnt counts STOP_HOLD cycles, then go to IDLE (STOPPED=1).
- EN is ignored in DRAIN and HOLD. A stop always completes; if EN is still 1 on return to IDLE, the block restarts on the next cycle.
- DIV changes outside IDLE are ignored. The divider is frozen until the next start.
- EN may be asynchronous to CLK; the caller synchronises it. It is sampled as-is.
- Reset mid-operation: outputs park immediately (asynchronously). Status: RUNNING=0, STOPPED=1.
- Counter width: cnt is DIV_W bits. DIV=2^DIV_W-1 is legal and gives the maximum period.

Decomposition:
- Package refclk_pkg holds:
  - the state enum (IDLE, START, RUN, DRAIN, HOLD);
  - pattern constants PAT_PARK=2'b00 and PAT_FULL=2'b01.
- Sub-module refclk_div_cnt: half-period counter plus phase toggle.
  - Inputs: load, div, run.
  - Outputs: phase, wrap.
  - Instantiated once.
- Top level contains the FSM, status counters and output registers.

Test Plan:
1. Reset: assert RST mid-cycle with no clock edge → P=00, N=11, RUNNING=0, STOPPED=1 immediately.
2. Full-rate start: DIV=0, EN=1 → STOPPED falls after 1 cycle. P=01 every cycle. RUNNING=1 exactly 1+16 cycles after EN. N=10 throughout.
3. Divide by 3: DIV=3, EN=1 → P sequence 11,11,11,00,00,00 repeating, starting at the first START cycle. Change DIV to 5 during RUN → period stays 6 cycles.
4. Glitch-free stop: DIV=4, drop EN on the 2nd cycle of a high half → P stays 11 for 2 more cycles, then 00. RUNNING falls on the edge after EN falls. STOPPED=1 exactly 4 HOLD cycles after parking.
5. Stop in low half and early stop: DIV=4, drop EN during a low half → park on the next cycle. Then EN=1 for only 5 cycles (within START) → DRAIN and HOLD; RUNNING never asserts.
6. Restart and reset races: EN toggles 1→0→1 within DRAIN → full HOLD completes, then IDLE for 1 cycle, then START with the newly latched DIV. RST asserted during RUN → immediate park, then a clean start when EN=1 after release.
